key_pick_decoder: RTL and testbench



---
 rtl/key_pick_decoder.sv | 195 +++++++++++++++++++
 tb/tb_key_pick_decoder.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/key_pick_decoder.sv
// Board-input front end for the tile-matching game: synchronises KEY/SW, detects presses
// and sequences new-game / first / second picks into a valid/ready pair. Optional KEY_DEBOUNCE_EN.
module key_pick_decoder #(
    parameter int unsigned DEBOUNCE_CYCLES = 2
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [9:0] SW,
    input  logic [2:0] KEY,
    output logic       new_game,
    output logic [3:0] first_idx,
    output logic [3:0] second_idx,
    output logic       pick_valid,
    input  logic       pick_ready,
    output logic       sel_err,
    output logic [1:0] state
);

    localparam int unsigned NKEY  = 3;
    localparam int unsigned NSW   = 10;
    localparam int unsigned IDX_W = 4;

    generate
        if (DEBOUNCE_CYCLES < 1) begin : g_param_check
            $error("DEBOUNCE_CYCLES must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PICK1    = 2'd1,
        PICK2    = 2'd2,
        WAIT_ACK = 2'd3
    } state_t;

    logic [NKEY-1:0]  key_s1_q, key_s2_q, key_filt;
    logic [NSW-1:0]   sw_s1_q, sw_s2_q;
    logic [NKEY-1:0]  lvl_q, press_q, armed_q;
    logic [1:0]       flush_q;
    logic [IDX_W-1:0] sw_cnt, sw_idx;
    logic             sw_ok;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] first_q, first_d, second_q, second_d;
    logic             valid_q, valid_d, ng_q, ng_d, err_q, err_d;

    // Two-flop synchronisers; KEY idles released (high)
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            key_s1_q <= '1;
            key_s2_q <= '1;
            sw_s1_q  <= '0;
            sw_s2_q  <= '0;
        end else begin
            key_s1_q <= KEY;
            key_s2_q <= key_s1_q;
            sw_s1_q  <= SW;
            sw_s2_q  <= sw_s1_q;
        end
    end

`ifdef KEY_DEBOUNCE_EN
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

    logic [CNT_W-1:0] cnt_q [NKEY];
    logic [NKEY-1:0]  filt_q;

    // Level is accepted after DEBOUNCE_CYCLES consecutive cycles of disagreement
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            filt_q <= '1;
            for (int k = 0; k < NKEY; k++) cnt_q[k] <= '0;
        end else begin
            for (int k = 0; k < NKEY; k++) begin
                if (key_s2_q[k] != filt_q[k]) begin
                    if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                        filt_q[k] <= key_s2_q[k];
                        cnt_q[k]  <= '0;
                    end else if (cnt_q[k] < CNT_W'(DEBOUNCE_CYCLES)) begin
                        cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                    end
                end else begin
                    cnt_q[k] <= '0;
                end
            end
        end
    end

    assign key_filt = filt_q;
`else
    assign key_filt = key_s2_q;
`endif

    // Falling-edge press pulses; a key only arms once seen released after reset,
    // so a key held through reset deassertion never reports a press
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            flush_q <= '0;
            lvl_q   <= '1;
            press_q <= '0;
            armed_q <= '0;
        end else begin
            flush_q <= {flush_q[0], 1'b1};
            lvl_q   <= key_filt;
            press_q <= armed_q & lvl_q & ~key_filt;
            armed_q <= armed_q | ({NKEY{flush_q[1]}} & key_s2_q & key_filt);
        end
    end

    always_comb begin
        sw_cnt = '0;
        sw_idx = '0;
        for (int i = 0; i < NSW; i++) begin
            if (sw_s2_q[i]) begin
                sw_cnt = sw_cnt + IDX_W'(1);
                sw_idx = IDX_W'(i);
            end
        end
        sw_ok = (sw_cnt == IDX_W'(1));
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            first_q  <= '0;
            second_q <= '0;
            valid_q  <= 1'b0;
            ng_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            first_q  <= first_d;
            second_q <= second_d;
            valid_q  <= valid_d;
            ng_q     <= ng_d;
            err_q    <= err_d;
        end
    end

    // New game overrides everything; pick presses are only honoured in their own state
    always_comb begin
        state_d  = state_q;
        first_d  = first_q;
        second_d = second_q;
        valid_d  = valid_q;
        ng_d     = 1'b0;
        err_d    = 1'b0;
        if (press_q[0]) begin
            ng_d     = 1'b1;
            state_d  = PICK1;
            valid_d  = 1'b0;
            first_d  = '0;
            second_d = '0;
        end else begin
            case (state_q)
                PICK1: begin
                    if (press_q[1]) begin
                        if (sw_ok) begin
                            first_d = sw_idx;
                            state_d = PICK2;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                PICK2: begin
                    if (press_q[2]) begin
                        if (sw_ok && (sw_idx != first_q)) begin
                            second_d = sw_idx;
                            valid_d  = 1'b1;
                            state_d  = WAIT_ACK;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                WAIT_ACK: begin
                    if (valid_q && pick_ready) begin
                        valid_d = 1'b0;
                        state_d = PICK1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign new_game   = ng_q;
    assign first_idx  = first_q;
    assign second_idx = second_q;
    assign pick_valid = valid_q;
    assign sel_err    = err_q;
    assign state      = state_q;

endmodule

// File: tb/tb_key_pick_decoder.sv
// Directed bench for key_pick_decoder: table of pick vectors plus latency, glitch,
// handshake-stability and reset-during-press sequences.
module tb_key_pick_decoder;

`ifdef KEY_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int unsigned DB_PARAM = (DB == 0) ? 2 : DB;
    localparam int HOLD   = DB + 2;
    localparam int SETTLE = DB + 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [9:0] SW;
    logic [2:0] KEY;
    logic       new_game, pick_valid, pick_ready, sel_err;
    logic [3:0] first_idx, second_idx;
    logic [1:0] state;

    int checks = 0;
    int failures = 0;
    int ng_seen = 0;
    int err_seen = 0;

    key_pick_decoder #(.DEBOUNCE_CYCLES(DB_PARAM)) dut (
        .CLOCK_50  (clk),
        .reset     (reset),
        .SW        (SW),
        .KEY       (KEY),
        .new_game  (new_game),
        .first_idx (first_idx),
        .second_idx(second_idx),
        .pick_valid(pick_valid),
        .pick_ready(pick_ready),
        .sel_err   (sel_err),
        .state     (state)
    );

    always #10 clk = ~clk;

    typedef struct {
        logic [2:0] mask;
        logic [9:0] sw;
        logic       rdy;
        logic [1:0] st;
        logic [3:0] f;
        logic [3:0] s;
        logic       v;
        int         ng;
        int         err;
    } vec_t;

    vec_t vecs [19];

    task automatic step();
        @(negedge clk);
        if (new_game) ng_seen++;
        if (sel_err) err_seen++;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        KEY = KEY & ~mask;
        repeat (hold) step();
        KEY = 3'b111;
        repeat (SETTLE) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        repeat (4) step();
        ng_seen  = 0;
        err_seen = 0;
    endtask

    initial begin
        int hit_step, hits;
        reset = 1'b1;
        KEY = 3'b111;
        SW = '0;
        pick_ready = 1'b0;

        vecs[0]  = '{3'b001, 10'h000, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0, 1, 0};
        vecs[1]  = '{3'b010, 10'h002, 1'b0, 2'd2, 4'd1, 4'd0, 1'b0, 0, 0};
        vecs[2]  = '{3'b100, 10'h004, 1'b0, 2'd3, 4'd1, 4'd2, 1'b1, 0, 0};
        vecs[3]  = '{3'b000, 10'h004, 1'b1, 2'd1, 4'd1, 4'd2, 1'b0, 0, 0};
        vecs[4]  = '{3'b010, 10'h006, 1'b0, 2'd1, 4'd1, 4'd2, 1'b0, 0, 1};
        vecs[5]  = '{3'b010, 10'h000, 1'b0, 2'd1, 4'd1, 4'd2, 1'b0, 0, 1};
        vecs[6]  = '{3'b100, 10'h004, 1'b0, 2'd1, 4'd1, 4'd2, 1'b0, 0, 0};
        vecs[7]  = '{3'b010, 10'h100, 1'b0, 2'd2, 4'd8, 4'd2, 1'b0, 0, 0};
        vecs[8]  = '{3'b100, 10'h100, 1'b0, 2'd2, 4'd8, 4'd2, 1'b0, 0, 1};
        vecs[9]  = '{3'b010, 10'h001, 1'b0, 2'd2, 4'd8, 4'd2, 1'b0, 0, 0};
        vecs[10] = '{3'b100, 10'h000, 1'b0, 2'd2, 4'd8, 4'd2, 1'b0, 0, 1};
        vecs[11] = '{3'b100, 10'h200, 1'b0, 2'd3, 4'd8, 4'd9, 1'b1, 0, 0};
        vecs[12] = '{3'b010, 10'h001, 1'b0, 2'd3, 4'd8, 4'd9, 1'b1, 0, 0};
        vecs[13] = '{3'b001, 10'h001, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0, 1, 0};
        vecs[14] = '{3'b010, 10'h008, 1'b0, 2'd2, 4'd3, 4'd0, 1'b0, 0, 0};
        vecs[15] = '{3'b100, 10'h010, 1'b0, 2'd3, 4'd3, 4'd4, 1'b1, 0, 0};
        vecs[16] = '{3'b101, 10'h020, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0, 1, 0};
        vecs[17] = '{3'b011, 10'h040, 1'b0, 2'd1, 4'd0, 4'd0, 1'b0, 1, 0};
        vecs[18] = '{3'b000, 10'h040, 1'b1, 2'd1, 4'd0, 4'd0, 1'b0, 0, 0};

        // Reset values, sampled while reset is held
        step();
        check("rst_state", int'(state), 0);
        check("rst_outputs", int'({new_game, first_idx, second_idx, pick_valid, sel_err}), 0);
        do_reset();
        check("rst_state_after", int'(state), 0);

        // Short low excursion on new-game key: a press without debounce, rejected with it
        press(3'b001, (DB == 0) ? 1 : 2);
        check("glitch_ng_count", ng_seen, (DB == 0) ? 1 : 0);
        check("glitch_state", int'(state), (DB == 0) ? 1 : 0);
        do_reset();

        // New-game latency: pulse seen on the (DB+4)th sample after driving KEY low
        hit_step = 0;
        hits = 0;
        KEY[0] = 1'b0;
        for (int i = 1; i <= DB + 8; i++) begin
            step();
            if (i == HOLD) KEY = 3'b111;
            if (new_game) begin
                hits++;
                if (hit_step == 0) hit_step = i;
            end
        end
        repeat (4) step();
        check("ng_latency", hit_step, DB + 4);
        check("ng_width", hits, 1);
        check("ng_state", int'(state), 1);
        do_reset();

        for (int r = 0; r < 19; r++) begin
            SW = vecs[r].sw;
            pick_ready = vecs[r].rdy;
            ng_seen = 0;
            err_seen = 0;
            press(vecs[r].mask, HOLD);
            pick_ready = 1'b0;
            check($sformatf("v%0d_state", r), int'(state), int'(vecs[r].st));
            check($sformatf("v%0d_first", r), int'(first_idx), int'(vecs[r].f));
            check($sformatf("v%0d_second", r), int'(second_idx), int'(vecs[r].s));
            check($sformatf("v%0d_valid", r), int'(pick_valid), int'(vecs[r].v));
            check($sformatf("v%0d_newgame", r), ng_seen, vecs[r].ng);
            check($sformatf("v%0d_selerr", r), err_seen, vecs[r].err);
        end

        // Pair held stable while the core stalls, then accepted on one edge
        SW = 10'h002;
        press(3'b010, HOLD);
        SW = 10'h004;
        press(3'b100, HOLD);
        check("hs_state", int'(state), 3);
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("hs_stall%0d", i), int'({pick_valid, first_idx, second_idx}), 9'h112);
        end
        pick_ready = 1'b1;
        step();
        pick_ready = 1'b0;
        check("hs_ack_valid", int'(pick_valid), 0);
        check("hs_ack_state", int'(state), 1);
        SW = 10'h008;
        press(3'b010, HOLD);
        check("hs_next_first", int'(first_idx), 3);
        check("hs_next_state", int'(state), 2);

        // Reset while the new-game key is mid-press and still held afterwards
        KEY[0] = 1'b0;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        ng_seen = 0;
        repeat (HOLD + 4) step();
        KEY = 3'b111;
        repeat (SETTLE) step();
        check("rstmid_ng_count", ng_seen, 0);
        check("rstmid_state", int'(state), 0);
        press(3'b001, HOLD);
        check("rstmid_recover_ng", ng_seen, 1);
        check("rstmid_recover_state", int'(state), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
